if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor to the combinational fetch-stage pass-through.
- Buffers fetched {pc, instr} pairs in a DEPTH-entry circular FIFO between instruction memory and decode, with valid/ready handshakes on both sides.
- Pre-decodes rs1, rs2 and the store (MemWrite) flag for the head entry, so hazard logic sees them before decode.
- Flush input discards all in-flight fetches on a redirect (branch/jump).

Parameters:
- XLEN, 32, width of pc and instruction words.
- DEPTH, 4, queue entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  discard all entries this cycle.
- in_valid  input  1  fetch side presents pc/instr.
- in_ready  output  1  queue can accept (= not full).
- in_pc  input  XLEN  fetched pc.
- in_instr  input  XLEN  fetched instruction.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes head.
- out_pc  output  XLEN  head pc; 0 when out_valid=0.
- out_instr  output  XLEN  head instruction; 0 when out_valid=0.
- out_rs1  output  5  out_instr[19:15]; 0 when out_valid=0.
- out_rs2  output  5  out_instr[24:20]; 0 when out_valid=0.
- out_memwrite  output  1  1 iff out_valid and out_instr[6:0]==7'b0100011.
- count  output  PTR_W+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, so out_valid=0 and all out_* = 0. in_ready=1 once rst deasserts. Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated on the rising edge.
- in_ready = (count != DEPTH), combinational from state only; it does not depend on out_ready. When full, no push is accepted even if a pop happens in the same cycle.
- out_valid = (count != 0). Head fields are read combinationally from entry rd_ptr.
- Push: writes entry wr_ptr, then wr_ptr+1 modulo DEPTH (natural wrap at PTR_W bits).
- Pop: rd_ptr+1 modulo DEPTH.
- count update: +1 on push only; -1 on pop only; unchanged on push+pop.
- Latency (without bypass): an accepted input appears at the outputs the cycle after the push edge, earliest.
- Simultaneous push+pop with count==1 is legal: the old head is consumed and the new entry becomes head next cycle.
- flush=1 has priority over push and pop:
  - next state is wr_ptr=rd_ptr=0, count=0;
  - in_valid is ignored that cycle, so a concurrent fetch is dropped;
  - a pop handshake in the flush cycle still counts as consumed by decode;
  - the queue holds nothing afterwards.
- in_ready during flush = normal value; callers must not rely on acceptance.
- Overflow/underflow cannot occur; count never exceeds DEPTH or goes negative.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro: IF_FETCH_QUEUE_BYPASS_EN.
- Defined, when count==0 and flush==0:
  - out_valid = in_valid, and out_pc/out_instr/predecode are driven combinationally from in_pc/in_instr;
  - if out_ready=1, the entry is consumed without being written; pointers and count are unchanged (zero-latency path);
  - if out_ready=0, it is pushed normally.
- Not defined: no combinational path from in_* to out_*; minimum latency is 1 cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> out_valid=0, count=0, in_ready=1, out_pc=0, out_rs1=0.
- Fill: push 4 entries with pc=0x0,0x4,0x8,0xC, out_ready=0 -> count=4, in_ready=0; a fifth in_valid (pc=0x10) is not accepted; out_pc=0x0.
- Drain and wrap: from full, out_ready=1 with pushes of pc=0x10,0x14 interleaved -> out_pc sequence 0x0,0x4,0x8,0xC,0x10,0x14 with no loss, across pointer wrap.
- Predecode: push instr=32'h00B52023 (sw x11,0(x10)) -> out_rs1=10, out_rs2=11, out_memwrite=1. Push 32'h00B50533 (add) -> out_memwrite=0.
- Flush: count=3 with flush=1 and in_valid=1 (pc=0x40) in the same cycle -> next cycle count=0, out_valid=0; pc=0x40 never appears at the output.
- Bypass (macro defined): empty queue, in_valid=1, in_pc=0x80, out_ready=1 -> out_valid=1 and out_pc=0x80 in the same cycle; count stays 0. Without the macro: out_valid=1 one cycle later.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Fetch queue: DEPTH-entry circular FIFO of {pc, instr} between instruction memory and decode,
// with head pre-decode (rs1, rs2, store flag). Define IF_FETCH_QUEUE_BYPASS_EN for the zero-latency empty-queue path.
module if_fetch_queue #(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_instr,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic             out_memwrite,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
   localparam logic [6:0]     OP_STORE  = 7'b0100011;

   logic [XLEN-1:0]  pc_mem_q    [DEPTH];
   logic [XLEN-1:0]  instr_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic             empty;
   logic             push;
   logic             pop;
   logic             head_valid;
   logic [XLEN-1:0]  head_pc;
   logic [XLEN-1:0]  head_instr;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q != FULL_CNT);
   // Storage pop only; a bypassed entry never touches the array or the pointers.
   assign pop      = ~empty & out_ready;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
   logic bypass;

   assign bypass     = empty & ~flush & in_valid;
   assign head_valid = ~empty | bypass;
   assign head_pc    = empty ? in_pc    : pc_mem_q[rd_ptr_q];
   assign head_instr = empty ? in_instr : instr_mem_q[rd_ptr_q];
   assign push       = in_valid & in_ready & ~(bypass & out_ready);
`else
   assign head_valid = ~empty;
   assign head_pc    = pc_mem_q[rd_ptr_q];
   assign head_instr = instr_mem_q[rd_ptr_q];
   assign push       = in_valid & in_ready;
`endif

   // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; count gates every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem_q[wr_ptr_q]    <= in_pc;
         instr_mem_q[wr_ptr_q] <= in_instr;
      end
   end

   assign out_valid    = head_valid;
   assign out_pc       = head_valid ? head_pc    : '0;
   assign out_instr    = head_valid ? head_instr : '0;
   assign out_rs1      = out_instr[19:15];
   assign out_rs2      = out_instr[24:20];
   assign out_memwrite = head_valid & (out_instr[6:0] == OP_STORE);
   assign count        = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_if_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);
`ifdef IF_FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [31:0] I_SW  = 32'h00B52023;
   localparam logic [31:0] I_ADD = 32'h00B50533;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc;
   logic [XLEN-1:0]  in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_instr;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic             out_memwrite;
   logic [PTR_W:0]   count;

   int n_cmp  = 0;
   int n_fail = 0;

   if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_instr     (in_instr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .out_rs1      (out_rs1),
      .out_rs2      (out_rs2),
      .out_memwrite (out_memwrite),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: an ordered list of entries waiting for decode.
   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   entry_t mq[$];
   int     m_n;
   bit     m_byp, m_pop, m_push;

   always @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         mq.delete();
      end else begin
         m_n    = mq.size();
         m_byp  = BYP && m_n == 0 && in_valid && out_ready;
         m_pop  = m_n != 0 && out_ready;
         m_push = in_valid && m_n != DEPTH && !m_byp;
         if (m_pop)  void'(mq.pop_front());
         if (m_push) mq.push_back('{pc: in_pc, instr: in_instr});
      end
   end

   logic            e_valid;
   logic [XLEN-1:0] e_pc, e_instr;

   always @(negedge clk) begin
      e_valid = mq.size() != 0 || (BYP && !rst && !flush && in_valid);
      e_pc    = '0;
      e_instr = '0;
      if (mq.size() != 0) begin
         e_pc    = mq[0].pc;
         e_instr = mq[0].instr;
      end else if (e_valid) begin
         e_pc    = in_pc;
         e_instr = in_instr;
      end
      check("m_out_valid", 64'(out_valid), 64'(e_valid));
      check("m_out_pc",    64'(out_pc),    64'(e_pc));
      check("m_out_instr", 64'(out_instr), 64'(e_instr));
      check("m_out_rs1",   64'(out_rs1),   64'(e_instr[19:15]));
      check("m_out_rs2",   64'(out_rs2),   64'(e_instr[24:20]));
      check("m_memwrite",  64'(out_memwrite), 64'(e_valid && e_instr[6:0] == 7'b0100011));
      check("m_in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
      check("m_count",     64'(count),     64'(mq.size()));
   end

   task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, '0, '0, ordy, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   logic [XLEN-1:0] drain_exp [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
   logic            drain_v   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [XLEN-1:0] drain_pc  [6] = '{32'h0, 32'h10, 32'h14, 32'h0, 32'h0, 32'h0};

   initial begin
      idle(1'b0);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count",     64'(count),     64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_pc",    64'(out_pc),    64'd0);
      check("rst_out_rs1",   64'(out_rs1),   64'd0);

      // Fill to DEPTH with decode stalled, then offer a fifth fetch.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'(4 * i), 32'h00000013 | 32'(i << 7), 1'b0, 1'b0);
         tick();
      end
      check("fill_count",    64'(count),    64'd4);
      check("fill_in_ready", 64'(in_ready), 64'd0);
      check("fill_out_pc",   64'(out_pc),   64'h0);
      drive(1'b1, 32'h10, 32'h13, 1'b0, 1'b0);
      tick();
      check("full_no_push_count", 64'(count),  64'd4);
      check("full_no_push_pc",    64'(out_pc), 64'h0);

      // Drain across the pointer wrap with two late pushes.
      for (int i = 0; i < 6; i++) begin
         drive(drain_v[i], drain_pc[i], 32'h13, 1'b1, 1'b0);
         #1;
         check("drain_valid", 64'(out_valid), 64'd1);
         check("drain_pc",    64'(out_pc),    64'(drain_exp[i]));
         tick();
      end
      idle(1'b0);
      check("drain_empty_count", 64'(count),     64'd0);
      check("drain_empty_valid", 64'(out_valid), 64'd0);

      // Predecode: store at head, then push+pop at count 1 replaces it with an add.
      drive(1'b1, 32'h30, I_SW, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h34, I_ADD, 1'b1, 1'b0);
      check("sw_rs1",      64'(out_rs1),      64'd10);
      check("sw_rs2",      64'(out_rs2),      64'd11);
      check("sw_memwrite", 64'(out_memwrite), 64'd1);
      tick();
      idle(1'b1);
      check("add_pc",       64'(out_pc),       64'h34);
      check("add_count",    64'(count),        64'd1);
      check("add_rs1",      64'(out_rs1),      64'd10);
      check("add_memwrite", 64'(out_memwrite), 64'd0);
      tick();

      // Flush with three entries and a concurrent fetch that must be dropped.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h20 + 32'(4 * i), I_ADD, 1'b0, 1'b0);
         tick();
      end
      check("preflush_count", 64'(count), 64'd3);
      drive(1'b1, 32'h40, I_ADD, 1'b0, 1'b1);
      tick();
      idle(1'b0);
      check("flush_count", 64'(count),     64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      repeat (3) tick();
      check("flush_dropped", 64'(out_valid), 64'd0);

      // Empty queue, fetch with decode ready.
      drive(1'b1, 32'h80, I_SW, 1'b1, 1'b0);
      #1;
      if (BYP) begin
         check("byp_same_valid", 64'(out_valid), 64'd1);
         check("byp_same_pc",    64'(out_pc),    64'h80);
         tick();
         idle(1'b0);
         check("byp_count", 64'(count), 64'd0);
      end else begin
         check("nobyp_same_valid", 64'(out_valid), 64'd0);
         tick();
         idle(1'b0);
         check("nobyp_next_valid", 64'(out_valid), 64'd1);
         check("nobyp_next_pc",    64'(out_pc),    64'h80);
         check("nobyp_count",      64'(count),     64'd1);
         idle(1'b1);
         tick();
      end

      // Mixed traffic: overlapping push/pop rates with occasional flushes.
      for (int i = 0; i < 60; i++) begin
         drive((i % 3) != 0, 32'h100 + 32'(4 * i),
               32'(i) * 32'h01020304 ^ ((i % 2) ? 32'h23 : 32'h33),
               (i % 4) < 2, (i % 17) == 16);
         tick();
      end
      idle(1'b1);
      repeat (DEPTH + 1) tick();
      check("final_count", 64'(count), 64'd0);

      // Asynchronous reset mid-operation.
      idle(1'b0);
      drive(1'b1, 32'h200, I_ADD, 1'b0, 1'b0);
      repeat (2) tick();
      idle(1'b0);
      #1 rst = 1'b1;
      #1;
      check("async_rst_count", 64'(count),     64'd0);
      check("async_rst_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
